ula_sequencer: RTL and testbench
================================

Name: ula_sequencer

Overview:
- Shares the single combinational ULA between two requesters (req0 = instruction control unit, req1 = auxiliary/debug port) using round-robin arbitration.
- Registers the operands for the ULA and holds them stable for an opcode-dependent number of settle cycles, which gives MUL and DIV multi-cycle timing.
- Returns the captured result and branch flag through a valid/ready response channel.
- One operation is outstanding at a time; there is no pipelining.

Parameters:
- DEF_CYCLES, 1, settle cycles for every opcode except MUL and DIV (must be ≥1).
- MUL_CYCLES, 2, settle cycles for opcode 5'b00110 (must be ≥1).
- DIV_CYCLES, 4, settle cycles for opcode 5'b00111 (must be ≥1).

Ports:
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_operando1 / req0_operando2  in  16 each  requester 0 operands.
- req0_opcode  in  5  requester 0 ULA opcode.
- req1_valid, req1_ready, req1_operando1, req1_operando2, req1_opcode  same as req0, for requester 1.
- ula_operando1 / ula_operando2  out  16 each  registered operands driven to the ULA.
- ula_opcode  out  5  registered opcode driven to the ULA.
- ula_resultado  in  32  ULA result.
- ula_data_uc  in  1  ULA branch-condition flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index that owns the response.
- rsp_resultado  out  32  captured result.
- rsp_data_uc  out  1  captured branch flag.
- rsp_div0  out  1  response was a divide by zero.

Behaviour:
- Reset values: state=IDLE, pointer=0 (req0 preferred), counter=0. All outputs are 0, including both readies, rsp_*, and ula_* (ula_opcode=5'b00000).
- States are IDLE, EXEC and RESP.
- IDLE, arbitration:
  - If only one requester's valid is high, that requester is granted.
  - If both are high, the requester other than the last-granted one is granted.
- IDLE, acceptance:
  - reqN_ready is combinational: (state==IDLE) & grantN. At most one ready is high in any cycle; both are 0 outside IDLE.
  - The handshake completes on the edge where valid & ready are both high.
  - On that edge: latch operands, opcode and id into the ula_* / id registers; update the pointer to the granted index; load counter = cycles(opcode) − 1.
- IDLE, divide by zero:
  - If the accepted opcode is 5'b00111 and operando2 == 0, go directly to RESP and skip the ULA.
  - Response is rsp_resultado = 32'hFFFFFFFF, rsp_data_uc = 0, rsp_div0 = 1.
  - ula_* are still loaded with the request values.
- IDLE, otherwise: go to EXEC.
- EXEC:
  - ula_* are held constant and the counter decrements each cycle.
  - When counter == 0: capture ula_resultado and ula_data_uc into rsp_resultado and rsp_data_uc, set rsp_div0 = 0, and go to RESP.
- Latency: rsp_valid rises N+1 edges after the accept edge, where N is the cycle count for the opcode (DEF = 2 edges, MUL = 3, DIV = 5). A divide by zero takes 1 edge.
- RESP:
  - rsp_valid = 1 and all rsp_* are held stable until rsp_ready is sampled high.
  - On that edge go to IDLE, clear rsp_valid, and return ula_* to 0.
  - Back-pressure is unlimited; new requests wait.
- In IDLE the ula_* outputs are 0, so the ULA sees opcode 0 (its default case).
- The block does not reinterpret the result; the 32-bit ULA output, including sign, is passed through unchanged.
- Requests must hold valid and payload stable until ready. Deasserting valid before the grant simply withdraws the request; there is no error and the pointer is unchanged.
- Reset in any state returns everything to the reset values on that edge. An in-flight operation is discarded and no response is produced.
- An opcode not implemented by the ULA uses DEF_CYCLES and returns whatever the ULA produces (0 in its default case).

Test Plan:
- Single ADD from req0: op1=16'd7, op2=16'd5, opcode 5'b00100. Expect req0_ready high for 1 cycle; rsp_valid 2 edges later with rsp_resultado=32'd12, rsp_id=0, rsp_div0=0.
- DIV timing: req1 sends 100/7, opcode 5'b00111. Expect ula_* stable for 4 cycles; rsp_valid 5 edges after accept; result 32'd14; rsp_id=1.
- Divide by zero: req0 sends 9/0. Expect rsp_valid 1 edge after accept, rsp_resultado=32'hFFFFFFFF, rsp_div0=1.
- Round robin: both requesters valid continuously with ADD, and rsp_ready tied high. Expect grants in the order 0,1,0,1. req1 is never starved, and the two readies are never high together.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Expect rsp_* unchanged and both readies 0 throughout; a new grant follows 1 cycle after rsp_ready=1.
- Reset mid-DIV: assert reset in the 2nd EXEC cycle. Expect on the next edge rsp_valid=0, ula_opcode=0, pointer=0 (req0 wins the next contention), and no stale response afterwards.

Source files
------------

// File: rtl/ula_sequencer.sv
// Round-robin front end for the shared ULA: registers operands, holds them for
// an opcode-dependent settle time, then returns the result on a valid/ready channel.
module ula_sequencer #(
  parameter int DEF_CYCLES = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_operando1,
  input  logic [15:0] req0_operando2,
  input  logic [4:0]  req0_opcode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_operando1,
  input  logic [15:0] req1_operando2,
  input  logic [4:0]  req1_opcode,
  output logic [15:0] ula_operando1,
  output logic [15:0] ula_operando2,
  output logic [4:0]  ula_opcode,
  input  logic [31:0] ula_resultado,
  input  logic        ula_data_uc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_resultado,
  output logic        rsp_data_uc,
  output logic        rsp_div0
);

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic [7:0]  cnt;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel;
  logic [15:0] sel_op1;
  logic [15:0] sel_op2;
  logic [4:0]  sel_opc;
  logic        div0;

  function automatic logic [7:0] cyc_m1(input logic [4:0] op);
    logic [7:0] r;
    case (op)
      OP_MUL:  r = 8'(MUL_CYCLES - 1);
      OP_DIV:  r = 8'(DIV_CYCLES - 1);
      default: r = 8'(DEF_CYCLES - 1);
    endcase
    return r;
  endfunction

  // prio names the requester that wins the next contention
  assign grant0 = req0_valid & (~req1_valid | ~prio);
  assign grant1 = req1_valid & (~req0_valid | prio);

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign sel        = grant1;

  assign sel_op1 = sel ? req1_operando1 : req0_operando1;
  assign sel_op2 = sel ? req1_operando2 : req0_operando2;
  assign sel_opc = sel ? req1_opcode    : req0_opcode;
  assign div0    = (sel_opc == OP_DIV) & (sel_op2 == 16'd0);

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div0 ? RESP : EXEC;
      EXEC: if (cnt == 8'd0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio          <= 1'b0;
      cnt           <= 8'd0;
      rsp_id        <= 1'b0;
      ula_operando1 <= 16'd0;
      ula_operando2 <= 16'd0;
      ula_opcode    <= 5'd0;
      rsp_resultado <= 32'd0;
      rsp_data_uc   <= 1'b0;
      rsp_div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ula_operando1 <= sel_op1;
            ula_operando2 <= sel_op2;
            ula_opcode    <= sel_opc;
            rsp_id        <= sel;
            prio          <= ~sel;
            cnt           <= cyc_m1(sel_opc);
            if (div0) begin
              rsp_resultado <= 32'hFFFF_FFFF;
              rsp_data_uc   <= 1'b0;
              rsp_div0      <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt == 8'd0) begin
            rsp_resultado <= ula_resultado;
            rsp_data_uc   <= ula_data_uc;
            rsp_div0      <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ula_operando1 <= 16'd0;
            ula_operando2 <= 16'd0;
            ula_opcode    <= 5'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// Bench for ula_sequencer: a small ULA model, a vector table and
// hand-written sequences for arbitration, back-pressure and reset.
module tb_ula_sequencer;

  logic        clock = 0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_operando1, req0_operando2;
  logic [4:0]  req0_opcode;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_operando1, req1_operando2;
  logic [4:0]  req1_opcode;
  logic [15:0] ula_operando1, ula_operando2;
  logic [4:0]  ula_opcode;
  logic [31:0] ula_resultado;
  logic        ula_data_uc;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_resultado;
  logic        rsp_data_uc, rsp_div0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ula_sequencer dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operando1(req0_operando1), .req0_operando2(req0_operando2),
    .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operando1(req1_operando1), .req1_operando2(req1_operando2),
    .req1_opcode(req1_opcode),
    .ula_operando1(ula_operando1), .ula_operando2(ula_operando2),
    .ula_opcode(ula_opcode), .ula_resultado(ula_resultado),
    .ula_data_uc(ula_data_uc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_resultado(rsp_resultado), .rsp_data_uc(rsp_data_uc),
    .rsp_div0(rsp_div0)
  );

  // reduced ULA: add, sub, mul, div, equality flag; 0 otherwise
  always_comb begin
    ula_resultado = 32'd0;
    ula_data_uc   = 1'b0;
    case (ula_opcode)
      5'b00100: ula_resultado = {16'd0, ula_operando1} + {16'd0, ula_operando2};
      5'b00101: ula_resultado = {16'd0, ula_operando1} - {16'd0, ula_operando2};
      5'b00110: ula_resultado = {16'd0, ula_operando1} * {16'd0, ula_operando2};
      5'b00111: if (ula_operando2 != 0)
        ula_resultado = {16'd0, ula_operando1 / ula_operando2};
      5'b01010: ula_data_uc = (ula_operando1 == ula_operando2);
      default: ;
    endcase
  end

  typedef struct {
    bit          id;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  opc;
    logic [31:0] res;
    bit          uc;
    bit          div0;
    int          lat;
  } vec_t;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          uc;
    bit          div0;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_res"}, rsp_resultado, e.res);
    chk({name, "_id"}, rsp_id, e.id);
    chk({name, "_uc"}, rsp_data_uc, e.uc);
    chk({name, "_div0"}, rsp_div0, e.div0);
  endtask

  always @(negedge clock) begin
    if (req0_ready && req1_ready) begin
      fails++;
      $display("FAIL both_ready: got 1 expected 0");
    end
  end

  task automatic drive(input bit id, input bit v, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] o);
    if (!id) begin
      req0_valid = v; req0_operando1 = a; req0_operando2 = b; req0_opcode = o;
    end else begin
      req1_valid = v; req1_operando1 = a; req1_operando2 = b; req1_opcode = o;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_op(input string name, input vec_t v);
    bit ok, stab;
    int lat;
    exp_t e;
    @(negedge clock);
    drive(v.id, 1, v.op1, v.op2, v.opc);
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (v.id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    chk({name, "_accept"}, ok, 1);
    if (!ok) begin drive(v.id, 0, 0, 0, 0); return; end
    @(posedge clock);
    e.id = v.id; e.res = v.res; e.uc = v.uc; e.div0 = v.div0;
    sb.push_back(e);
    @(negedge clock);
    drive(v.id, 0, 0, 0, 0);
    lat = 1;
    stab = 1;
    while (!rsp_valid && lat < 20) begin
      if (ula_opcode !== v.opc || ula_operando1 !== v.op1 ||
          ula_operando2 !== v.op2) stab = 0;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk({name, "_stable"}, stab, 1);
    chk({name, "_lat"}, lat, v.lat);
    if (rsp_valid) check_rsp(name);
    else chk({name, "_timeout"}, 0, 1);
    rsp_ready = 1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 0;
    chk({name, "_released"}, rsp_valid, 0);
    chk({name, "_ula_idle"}, ula_opcode, 0);
  endtask

  vec_t vecs[10];

  initial begin
    bit ok, flag;
    int g[$];
    exp_t e;

    vecs[0] = '{0, 16'd7,     16'd5,     5'b00100, 32'd12,        0, 0, 2};
    vecs[1] = '{1, 16'd100,   16'd7,     5'b00111, 32'd14,        0, 0, 5};
    vecs[2] = '{0, 16'd9,     16'd0,     5'b00111, 32'hFFFFFFFF,  0, 1, 1};
    vecs[3] = '{1, 16'd300,   16'd200,   5'b00110, 32'd60000,     0, 0, 3};
    vecs[4] = '{0, 16'd3,     16'd10,    5'b00101, 32'hFFFFFFF9,  0, 0, 2};
    vecs[5] = '{1, 16'd4,     16'd4,     5'b11111, 32'd0,         0, 0, 2};
    vecs[6] = '{0, 16'd5,     16'd5,     5'b01010, 32'd0,         1, 0, 2};
    vecs[7] = '{1, 16'hFFFF,  16'd1,     5'b00111, 32'h0000FFFF,  0, 0, 5};
    vecs[8] = '{0, 16'hFFFF,  16'hFFFF,  5'b00100, 32'h0001FFFE,  0, 0, 2};
    vecs[9] = '{1, 16'd0,     16'd0,     5'b00111, 32'hFFFFFFFF,  0, 1, 1};

    reset = 1;
    rsp_ready = 0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_ula_opcode", ula_opcode, 0);
    chk("rst_ula_op1", ula_operando1, 0);
    chk("rst_rsp_res", rsp_resultado, 0);
    chk("rst_rsp_div0", rsp_div0, 0);
    reset = 0;

    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // round robin from reset, both requesters always valid
    do_reset();
    drive(0, 1, 16'd1, 16'd1, 5'b00100);
    drive(1, 1, 16'd2, 16'd2, 5'b00100);
    rsp_ready = 1;
    #1;
    for (int i = 0; i < 40 && g.size() < 4; i++) begin
      if (rsp_valid) check_rsp("rr");
      if (req0_ready) begin
        g.push_back(0);
        e = '{0, 32'd2, 0, 0};
        sb.push_back(e);
      end
      if (req1_ready) begin
        g.push_back(1);
        e = '{1, 32'd4, 0, 0};
        sb.push_back(e);
      end
      @(negedge clock);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("rr_count", g.size(), 4);
    for (int i = 0; i < g.size(); i++)
      chk($sformatf("rr_grant%0d", i), g[i], i % 2);
    wait_rsp("rr_last", ok);
    if (ok) check_rsp("rr_last");
    @(negedge clock);
    rsp_ready = 0;
    sb.delete();

    // back-pressure with req1 waiting
    @(negedge clock);
    drive(0, 1, 16'd3, 16'd4, 5'b00100);
    #1;
    chk("bp_accept", req0_ready, 1);
    @(posedge clock);
    @(negedge clock);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 16'd10, 16'd20, 5'b00100);
    wait_rsp("bp", ok);
    flag = 1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_resultado !== 32'd7 || rsp_id !== 0 ||
          req0_ready || req1_ready) flag = 0;
      @(negedge clock);
    end
    chk("bp_hold", flag, 1);
    rsp_ready = 1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 0;
    chk("bp_regrant", req1_ready, 1);
    @(posedge clock);
    @(negedge clock);
    drive(1, 0, 0, 0, 0);
    e = '{1, 32'd30, 0, 0};
    sb.push_back(e);
    wait_rsp("bp2", ok);
    if (ok) check_rsp("bp2");
    rsp_ready = 1;
    @(negedge clock);
    rsp_ready = 0;

    // reset during the second EXEC cycle of a DIV
    @(negedge clock);
    drive(1, 1, 16'd100, 16'd7, 5'b00111);
    #1;
    chk("rd_accept", req1_ready, 1);
    @(posedge clock);
    @(negedge clock);
    drive(1, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("rd_rsp_valid", rsp_valid, 0);
    chk("rd_ula_opcode", ula_opcode, 0);
    chk("rd_ula_op1", ula_operando1, 0);
    reset = 0;
    flag = 1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) flag = 0;
      @(negedge clock);
    end
    chk("rd_no_stale", flag, 1);
    drive(0, 1, 16'd1, 16'd1, 5'b00100);
    drive(1, 1, 16'd2, 16'd2, 5'b00100);
    #1;
    chk("rd_ready0", req0_ready, 1);
    chk("rd_ready1", req1_ready, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
